// File: rtl/program_load_sequencer.sv
// program_load_sequencer: streams program beats into a core's instruction memory and register file,
// NOP-fills the pipeline, free-runs the core for a latched number of cycles, then reports done.
module program_load_sequencer #(
  parameter int RUN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_stage_1,
  input  logic                    start,
  input  logic                    halt,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [31:0]             ld_instr,
  input  logic signed [63:0]      ld_regdata,
  input  logic                    ld_last,
  input  logic [RUN_W-1:0]        run_cycles,
  output logic                    IMWrite,
  output logic [31:0]             instruction_in,
  output logic                    global_reg_write,
  output logic signed [63:0]      regfile_data_in,
  output logic                    core_reset,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              load_count
);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, cnt_q, cnt_d;
  logic imw_q, imw_d, gw_q, gw_d, crst_q, crst_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] instr_q, instr_d;
  logic signed [63:0] data_q, data_d;
  logic [7:0] lcnt_q, lcnt_d;
  logic accept, drain_w;
  assign ld_ready = (state_q == LOAD) & ~halt;
  assign accept = ld_ready & ld_valid;
  assign drain_w = (state_q == DRAIN) & ~halt;
  // cnt_q counts the four NOP-fill cycles in DRAIN, then is reused as the RUN cycle counter
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = start ? LOAD : IDLE;
        run_d = start ? run_cycles : run_q;
      end
      LOAD: begin
        state_d = halt ? DONE : (accept & ld_last) ? DRAIN : LOAD;
        cnt_d = '0;
      end
      DRAIN: begin
        cnt_d = (cnt_q == RUN_W'(3)) ? RUN_W'(1) : cnt_q + RUN_W'(1);
        state_d = halt ? DONE : (cnt_q != RUN_W'(3)) ? DRAIN : (run_q == '0) ? DONE : RUN;
      end
      RUN: begin
        cnt_d = cnt_q + RUN_W'(1);
        state_d = (halt | (cnt_q == run_q)) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
    imw_d = accept | drain_w;
    gw_d = accept;
    instr_d = accept ? ld_instr : drain_w ? 32'h0 : instr_q;
    data_d = accept ? ld_regdata : data_q;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    crst_d = (state_d == IDLE || state_d == DONE) ? 1'b1 : accept ? 1'b0 : crst_q;
    lcnt_d = (state_q == IDLE && start) ? 8'd0 : (accept && lcnt_q != 8'd255) ? lcnt_q + 8'd1 : lcnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset_stage_1) begin
      state_q <= IDLE;
      run_q <= '0;
      cnt_q <= '0;
      imw_q <= 1'b0;
      gw_q <= 1'b0;
      crst_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      instr_q <= '0;
      data_q <= '0;
      lcnt_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
      imw_q <= imw_d;
      gw_q <= gw_d;
      crst_q <= crst_d;
      busy_q <= busy_d;
      done_q <= done_d;
      instr_q <= instr_d;
      data_q <= data_d;
      lcnt_q <= lcnt_d;
    end
  end
  assign IMWrite = imw_q;
  assign global_reg_write = gw_q;
  assign instruction_in = instr_q;
  assign regfile_data_in = data_q;
  assign core_reset = crst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign load_count = lcnt_q;
endmodule

// File: tb/tb_program_load_sequencer.sv
// tb_program_load_sequencer: random and directed load/run sequences checked against a
// sequence-level model of the expected write stream, busy window, done pulse and core reset.
module tb_program_load_sequencer;
  logic clk = 1'b0;
  logic reset_stage_1, start, halt, ld_valid, ld_ready, ld_last;
  logic [31:0] ld_instr, instruction_in;
  logic signed [63:0] ld_regdata, regfile_data_in;
  logic [15:0] run_cycles;
  logic IMWrite, global_reg_write, core_reset, busy, done;
  logic [7:0] load_count;
  int tests = 0;
  int fails = 0;
  logic [31:0] bi[$];
  logic [63:0] bd[$];
  int gap[$];
  always #5 clk = ~clk;
  program_load_sequencer dut (
    .clk(clk), .reset_stage_1(reset_stage_1), .start(start), .halt(halt),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_instr(ld_instr), .ld_regdata(ld_regdata),
    .ld_last(ld_last), .run_cycles(run_cycles), .IMWrite(IMWrite), .instruction_in(instruction_in),
    .global_reg_write(global_reg_write), .regfile_data_in(regfile_data_in), .core_reset(core_reset),
    .busy(busy), .done(done), .load_count(load_count)
  );
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rand_beats(input int n, input int maxgap);
    bi.delete();
    bd.delete();
    gap.delete();
    for (int i = 0; i < n; i++) begin
      bi.push_back($urandom);
      bd.push_back({$urandom, $urandom});
      gap.push_back($urandom_range(0, maxgap));
    end
  endtask
  // Position p counts cycles from the first LOAD cycle; a beat accepted in cycle p shows in cycle p+1.
  task automatic run_seq(input int r, input int halt_at);
    int n, l, bl, w, first, nacc, b;
    int vb[$];
    bit halted;
    logic [511:0] e_busy, e_done, e_imw, e_gw, e_rdy, e_crst;
    logic [511:0] o_busy, o_done, o_imw, o_gw, o_rdy, o_crst;
    logic [31:0] e_i[$], o_i[$];
    logic [63:0] e_d[$], o_d[$];
    n = bi.size();
    halted = 0;
    for (int i = 0; i < n; i++) begin
      repeat (gap[i]) vb.push_back(-1);
      if (i == halt_at) begin
        vb.push_back(-2);
        halted = 1;
        break;
      end
      vb.push_back(i);
    end
    l = vb.size();
    bl = halted ? l + 1 : l + 5 + r;
    w = bl + 2;
    first = 1000;
    nacc = 0;
    foreach (vb[j]) if (vb[j] >= 0) begin
      if (first == 1000) first = j;
      nacc++;
      e_i.push_back(bi[vb[j]]);
      e_d.push_back(bd[vb[j]]);
    end
    if (!halted) repeat (4) e_i.push_back(32'h0);
    e_busy = '0; e_done = '0; e_imw = '0; e_gw = '0; e_rdy = '0; e_crst = '0;
    o_busy = '0; o_done = '0; o_imw = '0; o_gw = '0; o_rdy = '0; o_crst = '0;
    for (int p = 0; p < w; p++) begin
      e_busy[p] = p < bl;
      e_done[p] = p == bl - 1;
      e_gw[p] = p >= 1 && p <= l && vb[p-1] >= 0;
      e_imw[p] = e_gw[p] || (!halted && p > l && p <= l + 4);
      e_rdy[p] = p < l && vb[p] != -2;
      e_crst[p] = !(p > first && p < bl - 1);
    end
    run_cycles = 16'(r);
    start = 1'b1;
    halt = 1'b0;
    ld_valid = 1'($urandom);
    step();
    start = 1'b0;
    for (int p = 0; p < w; p++) begin
      o_busy[p] = busy;
      o_done[p] = done;
      o_imw[p] = IMWrite;
      o_gw[p] = global_reg_write;
      o_crst[p] = core_reset;
      if (IMWrite) o_i.push_back(instruction_in);
      if (global_reg_write) o_d.push_back(regfile_data_in);
      b = p < l ? vb[p] : -1;
      ld_instr = $urandom;
      ld_regdata = {$urandom, $urandom};
      ld_last = 1'($urandom);
      ld_valid = p < l ? b != -1 : 1'($urandom);
      halt = b == -2;
      start = p < bl ? 1'($urandom) : 1'b0;
      if (b >= 0) begin
        ld_instr = bi[b];
        ld_regdata = bd[b];
        ld_last = b == n - 1;
      end
      #1 o_rdy[p] = ld_ready;
      step();
    end
    ld_valid = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    check("busy", o_busy, e_busy);
    check("done", o_done, e_done);
    check("imwrite", o_imw, e_imw);
    check("gw", o_gw, e_gw);
    check("ld_ready", o_rdy, e_rdy);
    check("core_reset", o_crst, e_crst);
    check("n_instr", o_i.size(), e_i.size());
    foreach (e_i[k]) if (k < o_i.size()) check("instr", o_i[k], e_i[k]);
    check("n_data", o_d.size(), e_d.size());
    foreach (e_d[k]) if (k < o_d.size()) check("regdata", o_d[k], e_d[k]);
    check("load_count", load_count, nacc > 255 ? 255 : nacc);
  endtask
  task automatic paper_beats();
    bi = '{32'h00400133, 32'h010472B3, 32'h40C40333};
    bd = '{-64'sd32, -64'sd64, -64'sd2015};
    gap = '{0, 0, 0};
  endtask
  initial begin
    int dones, n;
    reset_stage_1 = 1'b1;
    start = 1'b1;
    halt = 1'b1;
    ld_valid = 1'b0;
    ld_instr = '0;
    ld_regdata = '0;
    ld_last = 1'b0;
    run_cycles = '0;
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_imwrite", IMWrite, 0);
    check("rst_gw", global_reg_write, 0);
    check("rst_instr", instruction_in, 0);
    check("rst_regdata", regfile_data_in, 0);
    check("rst_load_count", load_count, 0);
    reset_stage_1 = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    step();
    paper_beats();
    run_seq(5, -1);
    paper_beats();
    gap[1] = 1;
    run_seq(5, -1);
    bi = '{32'h00800133};
    bd = '{64'sd7};
    gap = '{0};
    run_seq(0, -1);
    paper_beats();
    run_seq(5, 1);
    rand_beats(3, 0);
    run_cycles = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_instr = bi[i];
      ld_regdata = bd[i];
      ld_last = i == 2;
      step();
    end
    ld_valid = 1'b0;
    repeat (6) step();
    check("busy_in_run", busy, 1);
    reset_stage_1 = 1'b1;
    start = 1'b1;
    halt = 1'b1;
    ld_valid = 1'b1;
    step();
    reset_stage_1 = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    ld_valid = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_core_reset", core_reset, 1);
    check("midrst_imwrite", IMWrite, 0);
    check("midrst_instr", instruction_in, 0);
    check("midrst_regdata", regfile_data_in, 0);
    check("midrst_load_count", load_count, 0);
    dones = 0;
    repeat (20) begin
      step();
      dones += int'(done);
    end
    check("midrst_no_done", dones, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    ld_valid = 1'b1;
    ld_instr = 32'hDEADBEEF;
    reset_stage_1 = 1'b1;
    step();
    reset_stage_1 = 1'b0;
    ld_valid = 1'b0;
    check("rstbeat_gw", global_reg_write, 0);
    check("rstbeat_imwrite", IMWrite, 0);
    check("rstbeat_load_count", load_count, 0);
    step();
    check("rstbeat_busy", busy, 0);
    for (int t = 0; t < 14; t++) begin
      n = $urandom_range(1, 8);
      rand_beats(n, 2);
      run_seq($urandom_range(0, 12), ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1);
    end
    rand_beats(260, 0);
    run_seq(2, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
